// File: rtl/toy_st_mem_resp_pkg.sv
// Shared types for the store-queue memory responder: request payload, bus opcodes,
// and the internal FIFO/pipe entry layouts.
package toy_pack;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    TOY_BUS_READ   = 2'd0,
    TOY_BUS_WRITE  = 2'd1,
    TOY_BUS_ATOMIC = 2'd2
  } toy_bus_op_e;

  typedef logic [7:0] mem_req_sideband_t;

  localparam int SB_WIDTH = $bits(mem_req_sideband_t);

  typedef struct packed {
    toy_bus_op_e              opcode;
    logic [ADDR_WIDTH-1:0]    mem_req_addr;
    logic [DATA_WIDTH-1:0]    mem_req_data;
    logic [STRB_WIDTH-1:0]    mem_req_strb;
    mem_req_sideband_t        mem_req_sideband;
  } agu_pkg;

  typedef struct packed {
    logic                     err;
    mem_req_sideband_t        sideband;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [STRB_WIDTH-1:0]    strb;
  } req_ent_t;

  typedef struct packed {
    logic                     err;
    mem_req_sideband_t        sideband;
  } rsp_ent_t;

  typedef struct packed {
    logic                     vld;
    logic                     err;
    mem_req_sideband_t        sideband;
  } pipe_stage_t;

  function automatic logic is_err_op(input toy_bus_op_e op);
    return op != TOY_BUS_WRITE;
  endfunction

endpackage

// File: rtl/toy_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module toy_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) push_i |-> !full_o);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop_i |-> !empty_o);

endmodule

// File: rtl/toy_st_mem_resp.sv
// Memory-side responder for store-queue writes: buffers requests, drives a
// byte-strobed SRAM write port, and returns in-order responses under a credit limit.
module toy_st_mem_resp
  import toy_pack::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_mem_req_vld,
  output logic                             s_mem_req_rdy,
  input  agu_pkg                           s_mem_req_pld,
  output logic                             sram_wr_en,
  input  logic                             sram_wr_rdy,
  output logic [ADDR_WIDTH-1:0]            sram_wr_addr,
  output logic [DATA_WIDTH-1:0]            sram_wr_data,
  output logic [DATA_WIDTH/8-1:0]          sram_wr_strb,
  output logic                             s_mem_rsp_vld,
  input  logic                             s_mem_rsp_rdy,
  output logic [SB_WIDTH-1:0]              s_mem_rsp_sideband,
  output logic                             s_mem_rsp_err,
  output logic [$clog2(REQ_DEPTH+1)-1:0]   req_cnt,
  output logic                             idle
);

  localparam int FW = $clog2(RSP_DEPTH + 1);

  req_ent_t    req_wdata, req_head;
  logic        req_push, req_pop, req_full, req_empty;

  rsp_ent_t    rsp_wdata, rsp_head;
  logic        rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [FW-1:0] rsp_cnt;

  logic [FW-1:0] in_flight_q, in_flight_d;
  logic [FW:0]   outstanding;
  logic          credit_ok, issue, err_pop, pipe_out;

  pipe_stage_t              pipe_in;
  pipe_stage_t [MEM_LAT-1:0] pipe_q, pipe_d;

  // Ready depends only on registered occupancy, never on the incoming valid.
  assign s_mem_req_rdy = ~rst & ~req_full;
  assign req_push      = s_mem_req_vld & s_mem_req_rdy;

  always_comb begin
    req_wdata          = '0;
    req_wdata.err      = is_err_op(s_mem_req_pld.opcode);
    req_wdata.sideband = s_mem_req_pld.mem_req_sideband;
    req_wdata.addr     = s_mem_req_pld.mem_req_addr;
    req_wdata.data     = s_mem_req_pld.mem_req_data;
    req_wdata.strb     = s_mem_req_pld.mem_req_strb;
  end

  toy_sync_fifo #(
    .WIDTH ($bits(req_ent_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_push),
    .wdata_i (req_wdata),
    .pop_i   (req_pop),
    .rdata_o (req_head),
    .full_o  (req_full),
    .empty_o (req_empty),
    .cnt_o   (req_cnt)
  );

  // A credit is held from issue until the response leaves, so the pipe never
  // needs to stall and the response FIFO can always absorb its output.
  assign outstanding = {1'b0, in_flight_q} + {1'b0, rsp_cnt};
  assign credit_ok   = outstanding < (FW+1)'(RSP_DEPTH);

  assign sram_wr_en   = ~req_empty & credit_ok & ~req_head.err;
  assign sram_wr_addr = req_head.addr;
  assign sram_wr_data = req_head.data;
  assign sram_wr_strb = req_head.strb;

  assign issue   = sram_wr_en & sram_wr_rdy;
  assign err_pop = ~req_empty & credit_ok & req_head.err;
  assign req_pop = issue | err_pop;

  always_comb begin
    pipe_in          = '0;
    pipe_in.vld      = req_pop;
    pipe_in.err      = req_head.err;
    pipe_in.sideband = req_head.sideband;
  end

  if (MEM_LAT == 1) begin : g_pipe_one
    assign pipe_d = pipe_in;
  end else begin : g_pipe_many
    assign pipe_d = {pipe_q[MEM_LAT-2:0], pipe_in};
  end

  assign pipe_out = pipe_q[MEM_LAT-1].vld;

  always_comb begin
    in_flight_d = in_flight_q;
    case ({req_pop, pipe_out})
      2'b10:   in_flight_d = in_flight_q + FW'(1);
      2'b01:   in_flight_d = in_flight_q - FW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q      <= '0;
      in_flight_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      in_flight_q <= in_flight_d;
    end
  end

  always_comb begin
    rsp_wdata          = '0;
    rsp_wdata.err      = pipe_q[MEM_LAT-1].err;
    rsp_wdata.sideband = pipe_q[MEM_LAT-1].sideband;
  end

  assign rsp_push = pipe_out;
  assign rsp_pop  = s_mem_rsp_vld & s_mem_rsp_rdy;

  toy_sync_fifo #(
    .WIDTH ($bits(rsp_ent_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_push),
    .wdata_i (rsp_wdata),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .cnt_o   (rsp_cnt)
  );

  assign s_mem_rsp_vld      = ~rsp_empty;
  assign s_mem_rsp_sideband = rsp_head.sideband;
  assign s_mem_rsp_err      = rsp_head.err;

  assign idle = req_empty & (in_flight_q == '0) & rsp_empty;

  a_req_no_push_full: assert property (@(posedge clk) disable iff (rst)
    req_push |-> !req_full);
  a_pipe_rsp_room: assert property (@(posedge clk) disable iff (rst)
    pipe_out |-> !rsp_full);
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    outstanding <= (FW+1)'(RSP_DEPTH));
  a_sram_hold: assert property (@(posedge clk) disable iff (rst)
    (sram_wr_en && !sram_wr_rdy) |=> (sram_wr_en && $stable(sram_wr_addr)
                                      && $stable(sram_wr_data) && $stable(sram_wr_strb)));

endmodule
